// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_UNC} state_t;

   localparam logic [3:0] UNC_PREFIX_DEF = 4'hF;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int tag_w(input int lines, input int line_words);
      return 30 - $clog2(lines) - $clog2(line_words);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: resettable valid/dirty bits, plus tag and data RAMs with
// one combinational read port and one word-write port.
module dcache_array import dcache_pkg::*; #(
   parameter int  LINES      = 64,
   parameter int  LINE_WORDS = 4,
   localparam int OFF_W      = off_w(LINE_WORDS),
   localparam int IDX_W      = idx_w(LINES),
   localparam int TAG_W      = tag_w(LINES, LINE_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [OFF_W-1:0] i_rd_off,
   output logic [31:0]      o_rd_data,
   output logic [TAG_W-1:0] o_rd_tag,
   output logic             o_rd_valid,
   output logic             o_rd_dirty,
   input  logic             i_wr_en,
   input  logic [OFF_W-1:0] i_wr_off,
   input  logic [31:0]      i_wr_data,
   input  logic             i_set_dirty,
   input  logic             i_fill_done,
   input  logic [TAG_W-1:0] i_fill_tag
);

   logic [LINES-1:0] r_valid;
   logic [LINES-1:0] r_dirty;
   logic [TAG_W-1:0] r_tag  [LINES];
   logic [31:0]      r_data [LINES*LINE_WORDS];

   logic [IDX_W+OFF_W-1:0] w_rd_addr;
   logic [IDX_W+OFF_W-1:0] w_wr_addr;

   assign w_rd_addr  = {i_idx, i_rd_off};
   assign w_wr_addr  = {i_idx, i_wr_off};
   assign o_rd_data  = r_data[w_rd_addr];
   assign o_rd_tag   = r_tag[i_idx];
   assign o_rd_valid = r_valid[i_idx];
   assign o_rd_dirty = r_dirty[i_idx];

   // Reset invalidates every line; any dirty data at that point is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill_done) begin
         r_valid[i_idx] <= 1'b1;
         r_dirty[i_idx] <= 1'b0;
      end else if (i_set_dirty) begin
         r_dirty[i_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (i_wr_en)     r_data[w_wr_addr] <= i_wr_data;
      if (i_fill_done) r_tag[i_idx]      <= i_fill_tag;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped D-cache controller with an
// uncached pass-through and a single-word memory handshake.
module dcache_ctrl import dcache_pkg::*; #(
   parameter int         LINES      = 64,
   parameter int         LINE_WORDS = 4,
   parameter logic [3:0] UNC_PREFIX = UNC_PREFIX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic [31:0] cache_rdata,
   output logic        data_sel,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(LINES);
   localparam int TAG_W = tag_w(LINES, LINE_WORDS);
   localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

   state_t           r_state, w_next;
   logic [OFF_W-1:0] r_cnt;
   logic             r_mem_cs, r_mem_we;
   logic [31:0]      r_mem_addr, r_mem_wdata;

   logic [OFF_W-1:0] w_off, w_rd_off, w_wr_off;
   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag, w_rd_tag;
   logic [31:0]      w_rd_data, w_wr_data;
   logic             w_rd_valid, w_rd_dirty, w_unc, w_hit, w_done, w_last;
   logic             w_wr_en, w_set_dirty, w_fill_done, w_unused;

   assign w_off    = cpu_addr[2 +: OFF_W];
   assign w_idx    = cpu_addr[2+OFF_W +: IDX_W];
   assign w_tag    = cpu_addr[31 -: TAG_W];
   assign w_unc    = (cpu_addr[31:28] == UNC_PREFIX);
   assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);
   assign w_done   = r_mem_cs && mem_ack;
   assign w_last   = (r_cnt == LAST);
   assign w_rd_off = (r_state == S_WB) ? r_cnt : w_off;
   assign w_unused = ^cpu_addr[1:0];

   assign cache_rdata = w_rd_data;
   assign mem_cs      = r_mem_cs;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;

   dcache_array #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) u_array (
      .clk        (clk),
      .rst        (rst),
      .i_idx      (w_idx),
      .i_rd_off   (w_rd_off),
      .o_rd_data  (w_rd_data),
      .o_rd_tag   (w_rd_tag),
      .o_rd_valid (w_rd_valid),
      .o_rd_dirty (w_rd_dirty),
      .i_wr_en    (w_wr_en),
      .i_wr_off   (w_wr_off),
      .i_wr_data  (w_wr_data),
      .i_set_dirty(w_set_dirty),
      .i_fill_done(w_fill_done),
      .i_fill_tag (w_tag)
   );

   always_comb begin
      w_next      = r_state;
      cpu_stall   = 1'b0;
      data_sel    = 1'b0;
      w_wr_en     = 1'b0;
      w_set_dirty = 1'b0;
      w_fill_done = 1'b0;
      w_wr_off    = w_off;
      w_wr_data   = cpu_wdata;
      case (r_state)
         S_IDLE: if (cpu_req) begin
            if (w_unc) begin
               cpu_stall = 1'b1;
               w_next    = S_UNC;
            end else if (w_hit) begin
               w_wr_en     = cpu_we;
               w_set_dirty = cpu_we;
            end else begin
               cpu_stall = 1'b1;
               w_next    = (w_rd_valid && w_rd_dirty) ? S_WB : S_FILL;
            end
         end
         S_WB: begin
            cpu_stall = 1'b1;
            if (w_done && w_last) w_next = S_FILL;
         end
         S_FILL: begin
            cpu_stall = 1'b1;
            w_wr_off  = r_cnt;
            w_wr_data = mem_rdata;
            if (w_done) begin
               w_wr_en = 1'b1;
               if (w_last) begin
                  w_fill_done = 1'b1;
                  w_next      = S_IDLE;
               end
            end
         end
         S_UNC: begin
            // Load data is handed to the pipeline straight from memory.
            if (w_done) begin
               data_sel = 1'b1;
               w_next   = S_IDLE;
            end else begin
               cpu_stall = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // A word is issued only from a cycle with mem_cs low, which gives the
   // mandatory one-cycle gap between consecutive words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mem_cs    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state <= w_next;
         if (r_mem_cs) begin
            if (mem_ack) begin
               r_mem_cs <= 1'b0;
               r_mem_we <= 1'b0;
               if (r_state != S_UNC) r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            case (r_state)
               S_WB: begin
                  r_mem_cs    <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= {w_rd_tag, w_idx, r_cnt, 2'b00};
                  r_mem_wdata <= w_rd_data;
               end
               S_FILL: begin
                  r_mem_cs   <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {w_tag, w_idx, r_cnt, 2'b00};
               end
               S_UNC: begin
                  r_mem_cs    <= 1'b1;
                  r_mem_we    <= cpu_we;
                  r_mem_addr  <= {cpu_addr[31:2], 2'b00};
                  r_mem_wdata <= cpu_wdata;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
